// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the multiply/divide sequencer.
package mdu_pkg;

    localparam int unsigned MDU_DW = 32;

    function automatic int unsigned mdu_cnt_w(input int unsigned dw);
        return $clog2(dw);
    endfunction

    localparam int unsigned MDU_CNT_W = mdu_cnt_w(MDU_DW);

    typedef enum logic [2:0] {
        MDU_OP_MULT  = 3'd0,
        MDU_OP_MULTU = 3'd1,
        MDU_OP_DIV   = 3'd2,
        MDU_OP_DIVU  = 3'd3,
        MDU_OP_MTHI  = 3'd4,
        MDU_OP_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_FIN  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// Accumulator is {upper half, lower half}; lower half holds multiplier / dividend bits.
module mdu_iter_step #(
    parameter int unsigned DW = 32
) (
    input  logic [2*DW-1:0] acc_i,
    input  logic [DW-1:0]   opnd_i,
    input  logic            div_i,
    output logic [2*DW-1:0] acc_o
);

    logic [DW:0] sum_c;
    logic [DW:0] diff_c;

    assign sum_c  = {1'b0, acc_i[2*DW-1:DW]} + {1'b0, opnd_i};
    // Trial subtract of the divisor from the partial remainder shifted left by one
    assign diff_c = acc_i[2*DW-1:DW-1] - {1'b0, opnd_i};

    always_comb begin
        acc_o = acc_i;
        if (div_i) begin
            if (!diff_c[DW]) begin
                acc_o = {diff_c[DW-1:0], acc_i[DW-2:0], 1'b1};
            end else begin
                acc_o = {acc_i[2*DW-2:0], 1'b0};
            end
        end else if (acc_i[0]) begin
            acc_o = {sum_c, acc_i[DW-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*DW-1:1]};
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MULT/DIV sequencer with HI/LO registers for the EXE stage.
// Operates on magnitudes; signs are applied in FIN just before HI/LO are written.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned DW = MDU_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [DW-1:0] src1,
    input  logic [DW-1:0] src2,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    localparam int unsigned CW = mdu_cnt_w(DW);
    localparam int unsigned AW = 2 * DW;

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [DW-1:0] opnd_q, opnd_d;
    logic [DW-1:0] hi_q, hi_d;
    logic [DW-1:0] lo_q, lo_d;
    logic          is_div_q, is_div_d;
    logic          neg_res_q, neg_res_d;
    logic          neg_rem_q, neg_rem_d;
    logic          dz_q, dz_d;

    logic          accept_c;
    logic          signed_c;
    logic [DW-1:0] mag1_c, mag2_c;
    logic [AW-1:0] step_acc_c;
    logic [AW-1:0] res_c;

    assign accept_c = req_valid && (state_q == MDU_IDLE) && !flush;
    assign signed_c = (req_op == MDU_OP_MULT) || (req_op == MDU_OP_DIV);
    assign mag1_c   = (signed_c && src1[DW-1]) ? -src1 : src1;
    assign mag2_c   = (signed_c && src2[DW-1]) ? -src2 : src2;

    mdu_iter_step #(.DW(DW)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (is_div_q),
        .acc_o  (step_acc_c)
    );

    // Sign fix-up of the finished magnitude result; divide-by-zero passes through raw
    always_comb begin
        res_c = acc_q;
        if (!dz_q) begin
            if (is_div_q) begin
                res_c[AW-1:DW] = neg_rem_q ? -acc_q[AW-1:DW] : acc_q[AW-1:DW];
                res_c[DW-1:0]  = neg_res_q ? -acc_q[DW-1:0]  : acc_q[DW-1:0];
            end else if (neg_res_q) begin
                res_c = -acc_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        unique case (state_q)
            MDU_IDLE: begin
                if (accept_c) begin
                    case (req_op)
                        MDU_OP_MULT, MDU_OP_MULTU: begin
                            acc_d     = {{DW{1'b0}}, mag2_c};
                            opnd_d    = mag1_c;
                            is_div_d  = 1'b0;
                            neg_res_d = signed_c && (src1[DW-1] ^ src2[DW-1]);
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b0;
                            cnt_d     = '0;
                            state_d   = MDU_CALC;
                        end
                        MDU_OP_DIV, MDU_OP_DIVU: begin
                            is_div_d = 1'b1;
                            if (src2 == '0) begin
                                acc_d   = {src1, {DW{1'b1}}};
                                dz_d    = 1'b1;
                                state_d = MDU_FIN;
                            end else begin
                                acc_d     = {{DW{1'b0}}, mag1_c};
                                opnd_d    = mag2_c;
                                neg_res_d = signed_c && (src1[DW-1] ^ src2[DW-1]);
                                neg_rem_d = signed_c && src1[DW-1];
                                dz_d      = 1'b0;
                                cnt_d     = '0;
                                state_d   = MDU_CALC;
                            end
                        end
                        MDU_OP_MTHI: hi_d = src1;
                        MDU_OP_MTLO: lo_d = src1;
                        default: ;
                    endcase
                end
            end
            MDU_CALC: begin
                acc_d = step_acc_c;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = MDU_FIN;
                end
                if (flush) begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_FIN: begin
                state_d = MDU_IDLE;
                if (!flush) begin
                    {hi_d, lo_d} = res_c;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign req_ready = (state_q == MDU_IDLE);
    assign busy      = (state_q != MDU_IDLE);
    assign done      = (state_q == MDU_FIN) && !flush;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_mdu_seq;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] src1, src2;
    logic        flush;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    mdu_seq #(.DW(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Architectural effect of one accepted MDU instruction on HI/LO
    task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        case (op)
            OP_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = 64'(sp);
            end
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                {m_hi, m_lo} = up;
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else if (op == OP_DIV) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    m_lo = 32'(sa / sb);
                    m_hi = 32'(sa % sb);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one request and wait (bounded) for done; returns in the done cycle
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat       = 0;
        busy_ok   = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Single-cycle request accepted in IDLE (MTHI/MTLO/no-op)
    task automatic issue_idle(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; src1 = '0; src2 = '0; flush = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (hi !== 32'd0)      begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0)      begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_mult();
        int lat; bit bok;
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, lat, bok);
        checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if (!bok)      begin errors++; $display("FAIL mult_busy: busy dropped during op"); end
        @(posedge clk); #1;
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mult_busy_after: got %b want 0", busy); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, lat, bok);
        @(posedge clk); #1;
        checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
        m_hi = hi === 32'h0000_0001 ? 32'h0000_0001 : 32'h0000_0001;
        m_lo = 32'hFFFF_FFFE;
    endtask

    task automatic test_div();
        int lat; bit bok;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bok);
        checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
        @(posedge clk); #1;
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
        @(posedge clk); #1;
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'd0)         begin errors++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, lat, bok);
        checks++; if (lat != 1) begin errors++; $display("FAIL divz_latency: got %0d want 1", lat); end
        @(posedge clk); #1;
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL divz_hi: got %h want 12345678", hi); end
        m_hi = 32'h1234_5678; m_lo = 32'hFFFF_FFFF;
    endtask

    task automatic test_flush();
        int lat; bit bok; bit saw_done;
        logic [31:0] hb, lb;
        hb = hi; lb = lo;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_DIV; src1 = 32'd100; src2 = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_pre: got %b want 1", busy); end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_post: got %b want 0", busy); end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL flush_no_done: got done pulse want none"); end
        checks++; if (hi !== hb || lo !== lb) begin errors++; $display("FAIL flush_hilo: got %h/%h want %h/%h", hi, lo, hb, lb); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy_pre: got %b want 0", busy); end
        issue_idle(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
        m_hi = 32'hA5A5_A5A5;
        checks++; if (hi !== 32'hA5A5_A5A5) begin errors++; $display("FAIL mthi_hi: got %h want a5a5a5a5", hi); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_busy: got busy=%b done=%b want 0/0", busy, done); end
        // Flush landing in FIN discards the result
        hb = hi; lb = lo;
        run_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000, lat, bok);
        flush = 1'b1;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_fin_done: got %b want 0", done); end
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if (hi !== hb || lo !== lb) begin errors++; $display("FAIL flush_fin_hilo: got %h/%h want %h/%h", hi, lo, hb, lb); end
    endtask

    task automatic test_flush_idle();
        logic [31:0] hb;
        hb = hi;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MTHI; src1 = 32'h1111_2222; flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (hi !== hb) begin errors++; $display("FAIL flush_idle_mthi: got %h want %h", hi, hb); end
        req_op = OP_MULT;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_mult: got busy %b want 0", busy); end
        req_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        logic [31:0] a2, b2;
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        run_op(OP_MULTU, 32'h0000_1234, 32'h0010_0000, lat, bok);
        ref_apply(OP_MULTU, 32'h0000_1234, 32'h0010_0000);
        req_valid = 1'b1; req_op = OP_DIVU; src1 = a2; src2 = b2;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_fin: got %b want 0", req_ready); end
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got ready=%b busy=%b want 1/0", req_ready, busy); end
        checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL b2b_first: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
        run_op(OP_DIVU, a2, b2, lat, bok);
        ref_apply(OP_DIVU, a2, b2);
        checks++; if (lat != 33 || !bok) begin errors++; $display("FAIL b2b_second_lat: got %0d busy_ok=%b want 33/1", lat, bok); end
        @(posedge clk); #1;
        checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL b2b_second: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_random();
        int lat, exp_lat; bit bok;
        logic [2:0] op; logic [31:0] a, b;
        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15)) ^ {32{$urandom_range(0, 1) == 1}};
                default: ;
            endcase
            ref_apply(op, a, b);
            if (op <= OP_DIVU) begin
                run_op(op, a, b, lat, bok);
                exp_lat = ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) ? 1 : 33;
                checks++; if (lat != exp_lat || !bok) begin errors++; $display("FAIL rand_lat op=%0d: got %0d busy_ok=%b want %0d", op, lat, bok, exp_lat); end
                @(posedge clk); #1;
            end else begin
                issue_idle(op, a, b);
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle_busy op=%0d: got %b want 0", op, busy); end
            end
            checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rand_hilo op=%0d a=%h b=%h: got %h/%h want %h/%h", op, a, b, hi, lo, m_hi, m_lo); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok;
        issue_idle(OP_MTLO, 32'h5A5A_0001, 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_MULT; src1 = 32'd123; src2 = 32'd456;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bok);
        ref_apply(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        @(posedge clk); #1;
        checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL rst_mid_after: got %h/%h want %h/%h", hi, lo, m_hi, m_lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_flush_idle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle multiply/divide sequencer with HI/LO registers for the EXE stage of the MIPS pipeline; serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Runs an iterative shift-add or shift-subtract datapath, one bit per cycle.
- Exposes a valid/ready request handshake, a busy flag for the pipeline stall logic, and a flush input so exceptions can cancel an in-flight operation.
- MFHI/MFLO read the hi/lo outputs directly.

Parameters:
- DW, 32, operand width; iteration count equals DW.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- req_valid  input  1  EXE presents an MDU instruction
- req_ready  output  1  sequencer can accept (state IDLE)
- req_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6-7 ignored (no-op)
- src1  input  DW  rs value (multiplicand / dividend / MTxx data)
- src2  input  DW  rt value (multiplier / divisor)
- flush  input  1  cancel current/pending operation (exception, eret)
- busy  output  1  state != IDLE; drives the EXE stall
- done  output  1  one-cycle pulse in FIN; HI/LO update at the end of this cycle
- hi  output  DW  HI register
- lo  output  DW  LO register

Behaviour:
- Reset (async, resetn=0): state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0, req_ready=1 as soon as reset releases. Reset mid-operation aborts immediately with no HI/LO update.
- accept = req_valid & req_ready & ~flush. flush in the same cycle as req_valid blocks acceptance.
- States: IDLE, CALC, FIN.
  - IDLE, accept of MULT/MULTU/DIV/DIVU with nonzero divisor: latch operand magnitudes (signed ops take the absolute value of each operand), latch result-sign flags, clear the counter, go to CALC.
  - IDLE, accept of DIV/DIVU with src2==0: go straight to FIN.
  - IDLE, accept of MTHI/MTLO: write hi or lo with src1 at that edge, stay in IDLE, no done pulse.
  - CALC: one iteration per cycle; counter increments; after DW iterations (counter==DW-1) go to FIN.
  - FIN: done=1; apply sign fixes; write hi/lo at the clock edge; go to IDLE. req_ready=0 in FIN.
- Latency: with accept at edge T, CALC occupies cycles T+1..T+DW and FIN occupies T+DW+1 (T+33 for DW=32). New hi/lo values are visible from T+DW+2. Divide by zero: FIN at T+1, hi/lo visible at T+2.
- Multiply: unsigned 2DW-bit shift-add over the magnitudes. If signed and the operand signs differ, negate the 2DW-bit product. {hi,lo} = product.
- Divide: restoring, one quotient bit per cycle over the magnitudes.
  - Signed: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - lo=quotient, hi=remainder.
  - Signed -2^31 / -1: lo=0x80000000, hi=0 (wraps, no trap).
- Divide by zero (signed or unsigned): lo=all-ones, hi=src1 unchanged.
- flush in CALC or FIN: state becomes IDLE at the next edge; no done pulse; hi/lo keep their prior values. flush in IDLE with no request has no effect.
- Back-to-back requests: the next request can be accepted at the earliest in the cycle after FIN. EXE holds req_valid and operands stable while req_ready=0.
- req_op 6/7: accepted, no state change, no writes.

Decomposition:
- Shared package mdu_pkg holds:
  - req_op encodings (MDU_OP_MULT..MDU_OP_MTLO)
  - state encodings (MDU_IDLE, MDU_CALC, MDU_FIN)
  - the DW-dependent counter width, $clog2(DW)
- One natural sub-module, mdu_iter_step: a combinational single-iteration step that takes {partial accumulator, shift operand, mode} and returns the next accumulator for shift-add (mul) or trial-subtract with quotient bit (div).
- mdu_seq holds the FSM, counter, sign handling and HI/LO registers.

Test Plan:
- MULT src1=0xFFFFFFFF, src2=0x00000002 -> done at T+33; then hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy high T+1..T+33.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV src1=0xFFFFFFF9 (-7), src2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU src1=0x12345678, src2=0 -> done at T+1; lo=0xFFFFFFFF, hi=0x12345678.
- Start DIV 100/7, assert flush at T+10 -> busy low from T+11, no done pulse, hi/lo unchanged. Then MTHI 0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle with busy never asserted.
- Drop resetn mid-MULT at T+5 -> hi=lo=0 and busy=0 immediately (asynchronously). Also: req_valid together with flush in IDLE -> not accepted, stays IDLE.
